// File: rtl/wb_ctrl.sv
// wb_ctrl: register-file write-port owner.
// Merges pipeline writes with buffered mul/div results and tracks pending rd.
module wb_ctrl #(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int FDEPTH = 2
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          pipe_wen_i,
    input  logic [AW-1:0] pipe_waddr_i,
    input  logic [DW-1:0] pipe_wdata_i,
    input  logic          md_issue_i,
    input  logic [AW-1:0] md_issue_rd_i,
    input  logic          md_valid_i,
    input  logic [AW-1:0] md_rd_i,
    input  logic [DW-1:0] md_data_i,
    output logic          md_ready_o,
    input  logic [AW-1:0] id_rs1_addr_i,
    input  logic [AW-1:0] id_rs2_addr_i,
    input  logic          id_rs1_read_i,
    input  logic          id_rs2_read_i,
    input  logic [AW-1:0] id_rd_i,
    input  logic          id_wen_i,
    output logic          hazard_o,
    output logic [31:0]   busy_o,
    output logic          wen_o,
    output logic [AW-1:0] wr_addr_o,
    output logic [DW-1:0] wr_data_o
);

    localparam int LW = $clog2(FDEPTH);
    localparam int PW = LW + 1;
    localparam logic [PW-1:0] PONE = 1;

    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic [AW-1:0] rd_mem  [FDEPTH];
    logic [DW-1:0] dat_mem [FDEPTH];
    logic [31:0]   busy;
    logic [31:0]   busy_nxt;

    logic          full;
    logic          empty;
    logic          pipe_act;
    logic          push;
    logic          pop;
    logic [AW-1:0] head_rd;
    logic [DW-1:0] head_data;

    assign full  = (wp[PW-1] != rp[PW-1]) &&
                   (wp[LW-1:0] == rp[LW-1:0]);
    assign empty = (wp == rp);

    assign md_ready_o = !full;

    // Writes to x0 are not real requests and leave the port free.
    assign pipe_act = pipe_wen_i && (pipe_waddr_i != '0);

    // Results for x0 are handshaken but never stored.
    assign push = md_valid_i && md_ready_o && (md_rd_i != '0);
    assign pop  = !pipe_act && !empty;

    assign head_rd   = rd_mem[rp[LW-1:0]];
    assign head_data = dat_mem[rp[LW-1:0]];

    // FIFO pointers; reset discards anything buffered.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) wp <= wp + PONE;
            if (pop)  rp <= rp + PONE;
        end
    end

    // FIFO storage.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < FDEPTH; i++) begin
                rd_mem[i]  <= '0;
                dat_mem[i] <= '0;
            end
        end else if (push) begin
            rd_mem[wp[LW-1:0]]  <= md_rd_i;
            dat_mem[wp[LW-1:0]] <= md_data_i;
        end
    end

    // Scoreboard update: clear on drain, then set on issue so set wins.
    always_comb begin
        busy_nxt = busy;
        if (pop) busy_nxt[head_rd] = 1'b0;
        if (md_issue_i && (md_issue_rd_i != '0))
            busy_nxt[md_issue_rd_i] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) busy <= '0;
        else       busy <= busy_nxt;
    end

    assign busy_o = busy;

    // RAW on either source, WAW on the destination.
    always_comb begin
        hazard_o = (id_rs1_read_i & busy[id_rs1_addr_i]) |
                   (id_rs2_read_i & busy[id_rs2_addr_i]) |
                   (id_wen_i      & busy[id_rd_i]);
    end

    // Write-port arbitration: pipeline first, then FIFO head.
    always_comb begin
        wen_o     = 1'b0;
        wr_addr_o = '0;
        wr_data_o = '0;
        if (pipe_act) begin
            wen_o     = 1'b1;
            wr_addr_o = pipe_waddr_i;
            wr_data_o = pipe_wdata_i;
        end else if (!empty) begin
            wen_o     = 1'b1;
            wr_addr_o = head_rd;
            wr_data_o = head_data;
        end
    end

endmodule

// File: tb/tb_wb_ctrl.sv
// tb_wb_ctrl: directed vectors for wb_ctrl.
// One vector per cycle, outputs checked before the capturing edge.
module tb_wb_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        pipe_wen_i;
    logic [4:0]  pipe_waddr_i;
    logic [31:0] pipe_wdata_i;
    logic        md_issue_i;
    logic [4:0]  md_issue_rd_i;
    logic        md_valid_i;
    logic [4:0]  md_rd_i;
    logic [31:0] md_data_i;
    logic        md_ready_o;
    logic [4:0]  id_rs1_addr_i;
    logic [4:0]  id_rs2_addr_i;
    logic        id_rs1_read_i;
    logic        id_rs2_read_i;
    logic [4:0]  id_rd_i;
    logic        id_wen_i;
    logic        hazard_o;
    logic [31:0] busy_o;
    logic        wen_o;
    logic [4:0]  wr_addr_o;
    logic [31:0] wr_data_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_ctrl #(.DW(32), .AW(5), .FDEPTH(2)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .pipe_wen_i    (pipe_wen_i),
        .pipe_waddr_i  (pipe_waddr_i),
        .pipe_wdata_i  (pipe_wdata_i),
        .md_issue_i    (md_issue_i),
        .md_issue_rd_i (md_issue_rd_i),
        .md_valid_i    (md_valid_i),
        .md_rd_i       (md_rd_i),
        .md_data_i     (md_data_i),
        .md_ready_o    (md_ready_o),
        .id_rs1_addr_i (id_rs1_addr_i),
        .id_rs2_addr_i (id_rs2_addr_i),
        .id_rs1_read_i (id_rs1_read_i),
        .id_rs2_read_i (id_rs2_read_i),
        .id_rd_i       (id_rd_i),
        .id_wen_i      (id_wen_i),
        .hazard_o      (hazard_o),
        .busy_o        (busy_o),
        .wen_o         (wen_o),
        .wr_addr_o     (wr_addr_o),
        .wr_data_o     (wr_data_o)
    );

    typedef struct {
        int unsigned pw, pa, pd;
        int unsigned mi, mir;
        int unsigned mv, mr, md;
        int unsigned r1, r1e, r2, r2e, rd, rde;
        int unsigned e_rdy, e_haz, e_busy, e_wen, e_wa, e_wd;
    } vec_t;

    vec_t vq[$];

    task automatic drive(input vec_t v);
        pipe_wen_i    = v.pw[0];
        pipe_waddr_i  = v.pa[4:0];
        pipe_wdata_i  = v.pd;
        md_issue_i    = v.mi[0];
        md_issue_rd_i = v.mir[4:0];
        md_valid_i    = v.mv[0];
        md_rd_i       = v.mr[4:0];
        md_data_i     = v.md;
        id_rs1_addr_i = v.r1[4:0];
        id_rs1_read_i = v.r1e[0];
        id_rs2_addr_i = v.r2[4:0];
        id_rs2_read_i = v.r2e[0];
        id_rd_i       = v.rd[4:0];
        id_wen_i      = v.rde[0];
    endtask

    task automatic check(input string nm, input vec_t v);
        total++;
        if (md_ready_o !== v.e_rdy[0] || hazard_o !== v.e_haz[0] ||
            busy_o !== v.e_busy || wen_o !== v.e_wen[0] ||
            wr_addr_o !== v.e_wa[4:0] || wr_data_o !== v.e_wd) begin
            bad++;
            $display("FAIL %s: got rdy=%0b haz=%0b busy=%h wen=%0b wa=%0d wd=%h want rdy=%0b haz=%0b busy=%h wen=%0b wa=%0d wd=%h",
                     nm, md_ready_o, hazard_o, busy_o, wen_o, wr_addr_o,
                     wr_data_o, v.e_rdy[0], v.e_haz[0], v.e_busy,
                     v.e_wen[0], v.e_wa[4:0], v.e_wd);
        end
    endtask

    initial begin
        vec_t idle;
        vec_t v;
        idle = '{0,0,0, 0,0, 0,0,0, 0,0,0,0,0,0, 1,0,0,0,0,0};

        //         pw pa pd           mi mir mv mr md           r1 e r2 e rd e  rdy hz busy         wen wa wd
        // pipeline only
        vq.push_back('{0,0,0,          0,0,  0,0,0,          0,0,0,0,0,0, 1,0,32'h0,      0,0,0});
        vq.push_back('{1,5,32'hDEADBEEF,0,0, 0,0,0,          0,0,0,0,0,0, 1,0,32'h0,      1,5,32'hDEADBEEF});
        vq.push_back('{1,0,32'h1234,   0,0,  0,0,0,          0,0,0,0,0,0, 1,0,32'h0,      0,0,0});
        // mul/div path to x7
        vq.push_back('{0,0,0,          1,7,  0,0,0,          7,1,0,0,0,0, 1,0,32'h0,      0,0,0});
        vq.push_back('{0,0,0,          0,0,  0,0,0,          7,1,0,0,0,0, 1,1,32'h80,     0,0,0});
        vq.push_back('{0,0,0,          0,0,  1,7,32'h12345678,7,1,0,0,0,0, 1,1,32'h80,     0,0,0});
        vq.push_back('{0,0,0,          0,0,  0,0,0,          7,1,0,0,0,0, 1,1,32'h80,     1,7,32'h12345678});
        vq.push_back('{0,0,0,          0,0,  0,0,0,          7,1,0,0,0,0, 1,0,32'h0,      0,0,0});
        // contention: issue x1..x3, then results while pipe owns the port
        vq.push_back('{0,0,0,          1,1,  0,0,0,          0,0,0,0,0,0, 1,0,32'h0,      0,0,0});
        vq.push_back('{0,0,0,          1,2,  0,0,0,          0,0,0,0,0,0, 1,0,32'h2,      0,0,0});
        vq.push_back('{0,0,0,          1,3,  0,0,0,          0,0,0,0,0,0, 1,0,32'h6,      0,0,0});
        vq.push_back('{1,9,32'h99,     0,0,  1,1,32'h11,     0,0,0,0,0,0, 1,0,32'hE,      1,9,32'h99});
        vq.push_back('{1,9,32'h99,     0,0,  1,2,32'h22,     0,0,0,0,0,0, 1,0,32'hE,      1,9,32'h99});
        vq.push_back('{1,9,32'h99,     0,0,  1,3,32'h33,     0,0,0,0,0,0, 0,0,32'hE,      1,9,32'h99});
        vq.push_back('{0,0,0,          0,0,  1,3,32'h33,     0,0,0,0,0,0, 0,0,32'hE,      1,1,32'h11});
        vq.push_back('{0,0,0,          0,0,  1,3,32'h33,     0,0,0,0,0,0, 1,0,32'hC,      1,2,32'h22});
        vq.push_back('{0,0,0,          0,0,  0,0,0,          0,0,0,0,0,0, 1,0,32'h8,      1,3,32'h33});
        vq.push_back('{0,0,0,          0,0,  0,0,0,          0,0,0,0,0,0, 1,0,32'h0,      0,0,0});
        // pop of x4 in the same cycle as a new issue to x4
        vq.push_back('{0,0,0,          1,4,  0,0,0,          0,0,0,0,0,0, 1,0,32'h0,      0,0,0});
        vq.push_back('{0,0,0,          0,0,  1,4,32'h44,     0,0,0,0,0,0, 1,0,32'h10,     0,0,0});
        vq.push_back('{0,0,0,          1,4,  0,0,0,          0,0,0,0,0,0, 1,0,32'h10,     1,4,32'h44});
        vq.push_back('{0,0,0,          0,0,  0,0,0,          0,0,0,0,0,0, 1,0,32'h10,     0,0,0});
        vq.push_back('{0,0,0,          0,0,  1,4,32'h45,     0,0,0,0,0,0, 1,0,32'h10,     0,0,0});
        vq.push_back('{0,0,0,          0,0,  0,0,0,          0,0,0,0,0,0, 1,0,32'h10,     1,4,32'h45});
        vq.push_back('{0,0,0,          0,0,  0,0,0,          0,0,0,0,0,0, 1,0,32'h0,      0,0,0});
        // WAW and source-enable checks against x10
        vq.push_back('{0,0,0,          1,10, 0,0,0,          0,0,0,0,0,0, 1,0,32'h0,      0,0,0});
        vq.push_back('{0,0,0,          0,0,  0,0,0,          0,0,0,0,10,1,1,1,32'h400,    0,0,0});
        vq.push_back('{0,0,0,          0,0,  0,0,0,          0,0,0,0,0,1, 1,0,32'h400,    0,0,0});
        vq.push_back('{0,0,0,          0,0,  0,0,0,          0,0,10,0,0,0,1,0,32'h400,    0,0,0});
        vq.push_back('{0,0,0,          0,0,  0,0,0,          0,0,10,1,0,0,1,1,32'h400,    0,0,0});
        // result for x0 is dropped
        vq.push_back('{0,0,0,          0,0,  1,0,32'h77,     0,0,0,0,0,0, 1,0,32'h400,    0,0,0});
        vq.push_back('{0,0,0,          0,0,  0,0,0,          0,0,0,0,0,0, 1,0,32'h400,    0,0,0});
        // pipe write to x0 lets the FIFO drain
        vq.push_back('{0,0,0,          0,0,  1,10,32'hAA,    0,0,0,0,0,0, 1,0,32'h400,    0,0,0});
        vq.push_back('{1,0,32'h55,     0,0,  0,0,0,          0,0,0,0,0,0, 1,0,32'h400,    1,10,32'hAA});
        vq.push_back('{0,0,0,          0,0,  0,0,0,          10,1,0,0,0,0,1,0,32'h0,      0,0,0});

        rstn = 1'b0;
        drive(idle);
        #2;
        check("reset", idle);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;

        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i]);
            #2;
            check($sformatf("vec%0d", i), vq[i]);
        end

        // async reset with a buffered result and a pending bit
        @(negedge clk);
        v = idle;
        v.mi = 1; v.mir = 5;
        drive(v);
        @(negedge clk);
        v = idle;
        v.pw = 1; v.pa = 9; v.pd = 32'h9;
        v.mv = 1; v.mr = 5; v.md = 32'h55;
        drive(v);
        @(negedge clk);
        v = idle;
        v.r1 = 5; v.r1e = 1;
        drive(v);
        #1;
        v.e_haz = 1; v.e_busy = 32'h20;
        v.e_wen = 1; v.e_wa = 5; v.e_wd = 32'h55;
        check("pre_rst", v);
        rstn = 1'b0;
        #1;
        v.e_haz = 0; v.e_busy = 0;
        v.e_wen = 0; v.e_wa = 0; v.e_wd = 0;
        check("async_rst", v);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        #1;
        check("post_rst", v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
